pilha_parametrizada: RTL and testbench
======================================

Name: pilha_parametrizada

Overview:
Parametrised LIFO stack that succeeds the fixed 8x8 stack used by the processor for JUMP/RETURN return addresses.
- Width and depth are configurable.
- Adds a combinational top-of-stack peek, an occupancy count and an almost-full threshold.
- Adds sticky overflow/underflow error flags and a defined same-cycle push+pop (replace-top) operation.
- Sits between the control unit and the PC/data path.

Parameters:
DATA_WIDTH, 8, bit width of each entry (>=1)
DEPTH, 8, number of entries (>=2)
ALMOST_FULL_LVL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
push  input  1  push request for this cycle
pop  input  1  pop request for this cycle
data_in  input  DATA_WIDTH  value to push
clear_err  input  1  clears the sticky overflow/underflow flags
data_out  output  DATA_WIDTH  registered value of the last accepted pop
pop_valid  output  1  one-cycle pulse: data_out updated by the pop accepted at the previous edge
top  output  DATA_WIDTH  combinational mem[count-1]; 0 when empty
count  output  $clog2(DEPTH+1)  number of stored entries
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=ALMOST_FULL_LVL
overflow  output  1  sticky: push refused because the stack was full
underflow  output  1  sticky: pop refused because the stack was empty

Behaviour:
- One clock domain: clk. reset is asynchronous and active-high and takes effect immediately, including mid-operation.
- Reset values: count=0, empty=1, full=0, almost_full=0, data_out=0, pop_valid=0, overflow=0, underflow=0, top=0. Storage array is not cleared.
- All state updates on the rising clk edge. count/flags/top reflect an operation immediately after that edge (1-cycle latency). Flags are derived from the registered count.
- Push only, not full: mem[count]<=data_in; count+1.
- Push only, full: ignored. overflow<=1. count, contents and top unchanged.
- Pop only, not empty: data_out<=mem[count-1]; pop_valid<=1; count-1.
- Pop only, empty: ignored. underflow<=1. pop_valid<=0. data_out holds.
- Push+pop, not empty (including full): replace-top.
  - data_out<=old top; pop_valid<=1; mem[count-1]<=data_in.
  - count unchanged; no overflow.
- Push+pop, empty: push performed (count=1, top=data_in). Pop refused: underflow<=1, pop_valid<=0.
- pop_valid is high only in the cycle following an accepted pop. data_out holds its value until the next accepted pop.
- clear_err clears overflow and underflow at the next edge. A new error in the same cycle wins (flag stays 1).
- count never exceeds DEPTH and never wraps below 0. No pointer wrap-around under any request sequence.
- Idle cycle (no push, no pop): all state holds; pop_valid<=0.

Test Plan:
1. Defaults; reset, push 0x11,0x22,0x33 -> count=3, top=0x33. Pop x3 -> data_out 0x33,0x22,0x11, each with pop_valid=1; then empty=1, top=0.
2. Push 0x01..0x08 -> almost_full=1 at count 7, full=1 at count 8. Push 0xFF -> count stays 8, top=0x08, overflow=1.
3. Empty, pop -> underflow=1, pop_valid=0, data_out unchanged. clear_err=1 -> underflow=0. clear_err together with another empty pop -> underflow stays 1.
4. Full (top 0x08), push+pop with 0xAA -> data_out=0x08, pop_valid=1, top=0xAA, count=8, overflow unchanged.
5. Empty, push+pop with 0x5A -> count=1, top=0x5A, underflow=1, pop_valid=0.
6. DATA_WIDTH=16, DEPTH=4: push 0x1234 x4, then reset asserted between edges -> all outputs at reset values before the next edge. Push 0x0077 -> count=1, top=0x0077.

Source files
------------

// File: rtl/pilha_parametrizada.sv
// Parametrised LIFO stack for return addresses: top-of-stack peek, occupancy,
// almost-full threshold, sticky overflow/underflow flags and push+pop replace-top.
module pilha_parametrizada #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_LVL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         clear_err,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         pop_valid,
    output logic [DATA_WIDTH-1:0]        top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  empty_w, full_w;
    logic                  push_ok, pop_ok;
    logic                  wr_en;
    logic [AW-1:0]         wr_idx, top_idx;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign top_idx = AW'(count_q - CW'(1));

    // A push on a full stack is only accepted when paired with a pop (replace-top).
    assign push_ok = push & (~full_w | pop);
    assign pop_ok  = pop & ~empty_w;

    always_comb begin
        count_d     = count_q;
        wr_en       = 1'b0;
        wr_idx      = AW'(count_q);
        data_out_d  = data_out_q;
        pop_valid_d = pop_ok;
        if (pop_ok) begin
            data_out_d = mem[top_idx];
        end
        if (push_ok && pop_ok) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_ok) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // A fresh error in the same cycle as clear_err keeps the flag set.
    assign overflow_d  = (push & ~pop & full_w) | (overflow_q & ~clear_err);
    assign underflow_d = (pop & empty_w) | (underflow_q & ~clear_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data_in;
        end
    end

    assign data_out    = data_out_q;
    assign pop_valid   = pop_valid_q;
    assign top         = empty_w ? '0 : mem[top_idx];
    assign count       = count_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign almost_full = (count_q >= CW'(ALMOST_FULL_LVL));
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pilha_parametrizada.sv
// Self-checking bench: directed vector table on an 8x8 stack plus a hand-written
// mid-cycle reset sequence on a 16x4 stack.
module tb_pilha_parametrizada;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       clr;
        logic [3:0] cnt;
        logic [7:0] top;
        logic       e;
        logic       f;
        logic       af;
        logic       ov;
        logic       un;
        logic       pv;
        logic [7:0] dout;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8 instance
    logic       reset, push, pop, clear_err;
    logic [7:0] data_in, data_out, top;
    logic       pop_valid, empty, full, almost_full, overflow, underflow;
    logic [3:0] count;

    pilha_parametrizada #(.DATA_WIDTH(8), .DEPTH(8)) u_dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .clear_err(clear_err), .data_out(data_out), .pop_valid(pop_valid),
        .top(top), .count(count), .empty(empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    // 16x4 instance
    logic        reset16, push16, pop16, clear_err16;
    logic [15:0] data_in16, data_out16, top16;
    logic        pop_valid16, empty16, full16, almost_full16, overflow16, underflow16;
    logic [2:0]  count16;

    pilha_parametrizada #(.DATA_WIDTH(16), .DEPTH(4)) u_dut16 (
        .clk(clk), .reset(reset16), .push(push16), .pop(pop16), .data_in(data_in16),
        .clear_err(clear_err16), .data_out(data_out16), .pop_valid(pop_valid16),
        .top(top16), .count(count16), .empty(empty16), .full(full16),
        .almost_full(almost_full16), .overflow(overflow16), .underflow(underflow16)
    );

    vec_t tbl[$];

    task automatic add(input logic pu, input logic po, input logic [7:0] d, input logic c,
                       input logic [3:0] cn, input logic [7:0] t, input logic e, input logic f,
                       input logic af, input logic ov, input logic un, input logic pv,
                       input logic [7:0] dout);
        vec_t v;
        v = '{pu, po, d, c, cn, t, e, f, af, ov, un, pv, dout};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] obs8();
        return 64'({count, top, empty, full, almost_full, overflow, underflow, pop_valid, data_out});
    endfunction

    function automatic logic [63:0] exp8(input vec_t v);
        return 64'({v.cnt, v.top, v.e, v.f, v.af, v.ov, v.un, v.pv, v.dout});
    endfunction

    function automatic logic [63:0] obs16();
        return 64'({count16, top16, empty16, full16, almost_full16, overflow16, underflow16,
                    pop_valid16, data_out16});
    endfunction

    function automatic logic [63:0] mk16(input logic [2:0] cn, input logic [15:0] t,
                                         input logic e, input logic f, input logic af,
                                         input logic pv, input logic [15:0] dout);
        return 64'({cn, t, e, f, af, 1'b0, 1'b0, pv, dout});
    endfunction

    initial begin
        //   pu po din   clr cnt top    e  f  af ov un pv dout
        add(1, 0, 8'h11, 0, 1, 8'h11, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 8'h22, 0, 2, 8'h22, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 8'h33, 0, 3, 8'h33, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 1, 8'h00, 0, 2, 8'h22, 0, 0, 0, 0, 0, 1, 8'h33);
        add(0, 1, 8'h00, 0, 1, 8'h11, 0, 0, 0, 0, 0, 1, 8'h22);
        add(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h11);
        add(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h11);
        for (int i = 1; i <= 8; i++)
            add(1, 0, 8'(i), 0, 4'(i), 8'(i), 0, (i == 8), (i >= 7), 0, 0, 0, 8'h11);
        add(1, 0, 8'hFF, 0, 8, 8'h08, 0, 1, 1, 1, 0, 0, 8'h11);
        add(1, 1, 8'hAA, 0, 8, 8'hAA, 0, 1, 1, 1, 0, 1, 8'h08);
        add(0, 0, 8'h00, 1, 8, 8'hAA, 0, 1, 1, 0, 0, 0, 8'h08);
        add(0, 1, 8'h00, 0, 7, 8'h07, 0, 0, 1, 0, 0, 1, 8'hAA);
        for (int i = 6; i >= 0; i--)
            add(0, 1, 8'h00, 0, 4'(i), 8'(i), (i == 0), 0, 0, 0, 0, 1, 8'(i + 1));
        add(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h01);
        add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h01);
        add(0, 1, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h01);
        add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h01);
        add(1, 1, 8'h5A, 0, 1, 8'h5A, 0, 0, 0, 0, 1, 0, 8'h01);
        add(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h5A);
        add(1, 0, 8'h10, 0, 1, 8'h10, 0, 0, 0, 0, 1, 0, 8'h5A);
        add(1, 1, 8'h20, 0, 1, 8'h20, 0, 0, 0, 0, 1, 1, 8'h10);

        reset = 1'b1; push = 0; pop = 0; data_in = '0; clear_err = 0;
        reset16 = 1'b1; push16 = 0; pop16 = 0; data_in16 = '0; clear_err16 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset8", obs8(), 64'({4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        chk("reset16", obs16(), mk16(3'd0, 16'h0, 1, 0, 0, 0, 16'h0));
        reset = 1'b0; reset16 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            push = tbl[i].push; pop = tbl[i].pop; data_in = tbl[i].din; clear_err = tbl[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), obs8(), exp8(tbl[i]));
        end
        push = 0; pop = 0; clear_err = 0;

        // 16x4: fill, pop once, then async reset between edges.
        data_in16 = 16'h1234;
        for (int i = 1; i <= 4; i++) begin
            push16 = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("fill16_%0d", i), obs16(),
                mk16(3'(i), 16'h1234, 0, (i == 4), (i >= 3), 0, 16'h0));
        end
        push16 = 1'b0; pop16 = 1'b1;
        @(posedge clk);
        #1;
        chk("pop16", obs16(), mk16(3'd3, 16'h1234, 0, 0, 1, 1, 16'h1234));
        pop16 = 1'b0;
        #2 reset16 = 1'b1;
        #1;
        chk("midreset16", obs16(), mk16(3'd0, 16'h0, 1, 0, 0, 0, 16'h0));
        #1 reset16 = 1'b0;
        push16 = 1'b1; data_in16 = 16'h0077;
        @(posedge clk);
        #1;
        chk("push16_after_reset", obs16(), mk16(3'd1, 16'h0077, 0, 0, 0, 0, 16'h0));
        push16 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
